xor_txn_sequencer: RTL and testbench
====================================

# xor_txn_sequencer

Bus-master controller that drives the register-mapped read/write interface of the XOR datapath block (A/B input FIFOs, Y result FIFO) on behalf of two requesters. It arbitrates operand pairs round-robin, writes operand A to address 4 and operand B to address 5, polls the Y-not-empty status at address 2, and reads the result from address 3. It returns a tagged response to the requester with a per-transaction timeout, and sits between the requester logic and the datapath's bus ports.

## Interface
- POLL_TIMEOUT, 15: max consecutive wait cycles in any wait state before abort; legal range 1-255.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req0_valid / req1_valid  in  1  requester has operand pair.
- req0_a / req1_a  in  1  operand A.
- req0_b / req1_b  in  1  operand B.
- req0_ready / req1_ready  out  1  pair accepted this cycle.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester index (0/1) of response.
- rsp_y  out  1  result bit.
- rsp_err  out  1  transaction aborted (timeout or check failure).
- rsp_ready  in  1  consumer takes response.
- bus_write_en  out  1  write strobe to datapath.
- bus_write_address  out  3  write address (4 = A, 5 = B).
- bus_write_data  out  1  write data.
- bus_write_rdy  in  1  target FIFO can accept; combinational from address.
- bus_read_en  out  1  read strobe.
- bus_read_address  out  3  read address (2 = Y status, 3 = Y data).
- bus_read_data  in  1  combinational read data, valid same cycle as address.
- bus_read_rdy  in  1  read interface ready.

## Operation
- States: IDLE, WR_A, WR_B, POLL, RD_Y, RESP.
- IDLE
  - If any req*_valid, grant one: both valid picks the requester not granted last; after reset req0 has priority.
  - Assert only that reqN_ready for one cycle.
  - Latch a, b, id; go WR_A.
- WR_A
  - bus_write_address=4, bus_write_data=a.
  - bus_write_en = bus_write_rdy; never assert en without rdy.
  - A cycle with en&rdy completes the write; go WR_B.
- WR_B: same as WR_A with address 5, data b; completion goes to POLL.
- POLL
  - bus_read_address=2, bus_read_en=bus_read_rdy.
  - en&&bus_read_data==1 goes to RD_Y.
- RD_Y
  - bus_read_address=3, bus_read_en=bus_read_rdy.
  - When en: capture bus_read_data into rsp_y; go RESP.
- Timeout counter (8 bit)
  - Cleared on entry to WR_A, WR_B, POLL.
  - Increments each cycle the state's completion condition is false.
  - Reaching POLL_TIMEOUT goes to RESP with rsp_err=1, rsp_y=0; no further bus access for that transaction.
- RESP
  - rsp_valid=1; rsp_id/rsp_y/rsp_err held stable until rsp_ready.
  - rsp_valid&&rsp_ready goes to IDLE and updates the round-robin pointer to rsp_id.
- Requests arriving while not IDLE wait with ready=0. A requester may drop valid before grant without effect.
- Bus addresses and data drive 0 when their en is not asserted.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, RR pointer = "last granted 1" (req0 preferred).
- RST mid-transaction: next cycle IDLE, outputs 0. In-flight transaction dropped, no response, partial FIFO writes not undone.
- Best case, handshake at cycle T:
  - WR_A write at T+1, WR_B at T+2, status read at T+3, data read at T+4.
  - rsp_valid high at T+5.
- rsp_ready already high in RESP: one-cycle response, IDLE at T+6, next grant at T+6. Peak throughput is 1 transaction per 6 cycles.
- Each stall cycle in WR_A/WR_B/POLL adds one cycle.
- Timeout abort: RESP entered in the cycle after the counter reaches POLL_TIMEOUT.
- Exactly one bus strobe (write_en or read_en) per cycle at most.

## Configuration
- XOR_SEQ_CHECK_EN defined:
  - In RD_Y, compare the captured result to a^b computed from latched operands.
  - Mismatch sets rsp_err=1, with rsp_y still carrying the read value.
- Undefined: no comparator; rsp_err reflects timeout only.

## Test plan
- Single req0 a=1,b=1, all rdy high -> writes (4,1),(5,1) at T+1/T+2, reads addr 2 then 3; rsp_valid at T+5 with id=0, y=0, err=0.
- req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; first grant req0 after reset.
- bus_write_rdy low 3 cycles in WR_B -> bus_write_en stays 0 for those cycles; response 3 cycles later, err=0.
- Status read_data held 0, POLL_TIMEOUT=4 -> rsp_err=1, y=0 after 4 poll cycles; no address-3 read issued.
- RST pulsed during POLL -> next cycle all outputs 0, no rsp_valid; a new req0 completes normally.
- XOR_SEQ_CHECK_EN with a=1,b=0 and forced read y=0 -> rsp_err=1, rsp_y=0; without macro rsp_err=0.

Source files
------------

// File: rtl/xor_txn_sequencer.sv
// xor_txn_sequencer: round-robin bus master for the XOR datapath (write A/B, poll Y, read Y, tagged response).
// Define XOR_SEQ_CHECK_EN to flag results that disagree with a^b of the latched operands.
module xor_txn_sequencer #(
    parameter int POLL_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic       req0_a,
    input  logic       req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_a,
    input  logic       req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_y,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic       bus_write_en,
    output logic [2:0] bus_write_address,
    output logic       bus_write_data,
    input  logic       bus_write_rdy,
    output logic       bus_read_en,
    output logic [2:0] bus_read_address,
    input  logic       bus_read_data,
    input  logic       bus_read_rdy
);
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, POLL, RD_Y, RESP} state_t;
    state_t state_q, state_d;
    logic a_q, a_d, b_q, b_d, id_q, id_d, y_q, y_d, err_q, err_d, last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic grant1, done, waiting, timeout, chk_err;

    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_q);
        req0_ready = state_q == IDLE && req0_valid && !grant1;
        req1_ready = state_q == IDLE && grant1;
        bus_write_en = (state_q == WR_A || state_q == WR_B) && bus_write_rdy;
        bus_write_address = !bus_write_en ? 3'd0 : state_q == WR_A ? 3'd4 : 3'd5;
        bus_write_data = bus_write_en && (state_q == WR_A ? a_q : b_q);
        bus_read_en = (state_q == POLL || state_q == RD_Y) && bus_read_rdy;
        bus_read_address = !bus_read_en ? 3'd0 : state_q == POLL ? 3'd2 : 3'd3;
        rsp_valid = state_q == RESP;
        rsp_id = rsp_valid && id_q;
        rsp_y = rsp_valid && y_q;
        rsp_err = rsp_valid && err_q;
        // POLL only completes once the status read reports a result waiting
        done = bus_write_en || (bus_read_en && (state_q == RD_Y || bus_read_data));
        waiting = state_q inside {WR_A, WR_B, POLL, RD_Y};
        timeout = waiting && !done && cnt_q + 8'd1 >= 8'(POLL_TIMEOUT);
`ifdef XOR_SEQ_CHECK_EN
        chk_err = bus_read_data != (a_q ^ b_q);
`else
        chk_err = 1'b0;
`endif
        cnt_d = waiting && !done && !timeout ? cnt_q + 8'd1 : 8'd0;
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        id_d = id_q;
        y_d = y_q;
        err_d = err_q;
        last_d = last_q;
        if (timeout) begin
            state_d = RESP;
            y_d = 1'b0;
            err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (req0_ready || req1_ready) begin
                    state_d = WR_A;
                    a_d = grant1 ? req1_a : req0_a;
                    b_d = grant1 ? req1_b : req0_b;
                    id_d = grant1;
                    y_d = 1'b0;
                    err_d = 1'b0;
                end
                WR_A: state_d = done ? WR_B : WR_A;
                WR_B: state_d = done ? POLL : WR_B;
                POLL: state_d = done ? RD_Y : POLL;
                RD_Y: if (done) begin
                    state_d = RESP;
                    y_d = bus_read_data;
                    err_d = chk_err;
                end
                RESP: if (rsp_ready) begin
                    state_d = IDLE;
                    last_d = id_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q <= 1'b0;
            b_q <= 1'b0;
            id_q <= 1'b0;
            y_q <= 1'b0;
            err_q <= 1'b0;
            last_q <= 1'b1;
            cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            id_q <= id_d;
            y_q <= y_d;
            err_q <= err_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_xor_txn_sequencer.sv
// tb_xor_txn_sequencer: directed and randomized checks of xor_txn_sequencer against a queue-based datapath
// and response scoreboard; expected error flags follow XOR_SEQ_CHECK_EN when it is defined.
module tb_xor_txn_sequencer;
    localparam int PT = 4;
`ifdef XOR_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req0_a = 0, req0_b = 0, req1_valid = 0, req1_a = 0, req1_b = 0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_err;
    logic rsp_ready = 0;
    logic bus_write_en, bus_write_data, bus_read_en, bus_read_data;
    logic [2:0] bus_write_address, bus_read_address;
    logic bus_write_rdy = 1, bus_read_rdy = 1;
    int checks = 0, passes = 0;
    logic last_id = 1;

    // behavioural datapath: A FIFO, Y FIFO holding a^b, optional forced read data
    logic aq[$], yq[$];
    logic y_ne = 0, y_head = 0, clr = 0;
    logic force_en = 0, force_status = 0, force_data = 0;
    logic pw_en = 0, pw_data = 0, pr_en = 0;
    logic [2:0] pw_addr = 0, pr_addr = 0;

    xor_txn_sequencer #(.POLL_TIMEOUT(PT)) dut (
        .CLK(clk), .RST(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .bus_write_en(bus_write_en), .bus_write_address(bus_write_address),
        .bus_write_data(bus_write_data), .bus_write_rdy(bus_write_rdy),
        .bus_read_en(bus_read_en), .bus_read_address(bus_read_address),
        .bus_read_data(bus_read_data), .bus_read_rdy(bus_read_rdy)
    );

    always #5 clk = ~clk;

    assign bus_read_data = force_en ? (bus_read_address == 3'd2 ? force_status : force_data)
                                    : (bus_read_address == 3'd2 ? y_ne : y_head);

    always @(negedge clk) begin
        pw_en = bus_write_en;
        pw_addr = bus_write_address;
        pw_data = bus_write_data;
        pr_en = bus_read_en;
        pr_addr = bus_read_address;
    end

    always @(posedge clk) begin
        #1;
        if (clr) begin
            aq.delete();
            yq.delete();
        end else begin
            if (pw_en && pw_addr == 3'd4) aq.push_back(pw_data);
            if (pw_en && pw_addr == 3'd5 && aq.size() != 0) yq.push_back(aq.pop_front() ^ pw_data);
            if (pr_en && pr_addr == 3'd3 && yq.size() != 0) void'(yq.pop_front());
        end
        y_ne = yq.size() != 0;
        y_head = y_ne ? yq[0] : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_err, bus_write_en, bus_write_address,
             bus_write_data, bus_read_en, bus_read_address} !== 14'd0)
            $display("FAIL reset_outputs: got en w=%b r=%b rsp_valid=%b expected all zero", bus_write_en, bus_read_en, rsp_valid);
        else passes++;
        rst = 0;
        tick();
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, bus_write_en, bus_read_en} !== 5'd0)
            $display("FAIL reset_release: got %b expected 00000", {req0_ready, req1_ready, rsp_valid, bus_write_en, bus_read_en});
        else passes++;
        last_id = 1;
    endtask

    task automatic test_round_robin();
        logic eid[$], ey[$];
        int last_g = -1, nrsp = 0, cyc = 0;
        req0_valid = 1;
        req1_valid = 1;
        rsp_ready = 1;
        while (nrsp < 8 && cyc < 200) begin
            req0_a = 1'($urandom); req0_b = 1'($urandom);
            req1_a = 1'($urandom); req1_b = 1'($urandom);
            #1;
            if (req0_ready || req1_ready) begin
                checks++;
                if ({req0_ready, req1_ready} !== (last_id ? 2'b10 : 2'b01))
                    $display("FAIL rr_grant: got %b expected %b", {req0_ready, req1_ready}, last_id ? 2'b10 : 2'b01);
                else passes++;
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g != 6) $display("FAIL rr_spacing: got %0d expected 6", cyc - last_g);
                    else passes++;
                end
                last_g = cyc;
                eid.push_back(req1_ready);
                ey.push_back(req1_ready ? req1_a ^ req1_b : req0_a ^ req0_b);
            end
            if (rsp_valid) begin
                checks++;
                if (eid.size() == 0 || {rsp_id, rsp_y, rsp_err} !== {eid[0], ey[0], 1'b0})
                    $display("FAIL rr_rsp: got id=%b y=%b err=%b", rsp_id, rsp_y, rsp_err);
                else passes++;
                if (eid.size() != 0) begin
                    last_id = eid.pop_front();
                    void'(ey.pop_front());
                end
                nrsp++;
            end
            tick();
            cyc++;
        end
        req0_valid = 0;
        req1_valid = 0;
        checks++;
        if (nrsp != 8) $display("FAIL rr_count: got %0d responses expected 8", nrsp);
        else passes++;
        rsp_ready = 0;
        tick();
    endtask

    task automatic test_single();
        req0_a = 1; req0_b = 1; req0_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready});
        else passes++;
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if ({bus_write_en, bus_write_address, bus_write_data, bus_read_en} !== {1'b1, 3'd4, 1'b1, 1'b0})
            $display("FAIL single_wr_a: got en=%b addr=%0d data=%b", bus_write_en, bus_write_address, bus_write_data);
        else passes++;
        tick();
        #1;
        checks++;
        if ({bus_write_en, bus_write_address, bus_write_data, bus_read_en} !== {1'b1, 3'd5, 1'b1, 1'b0})
            $display("FAIL single_wr_b: got en=%b addr=%0d data=%b", bus_write_en, bus_write_address, bus_write_data);
        else passes++;
        tick();
        #1;
        checks++;
        if ({bus_write_en, bus_read_en, bus_read_address} !== {1'b0, 1'b1, 3'd2})
            $display("FAIL single_poll: got wen=%b ren=%b addr=%0d", bus_write_en, bus_read_en, bus_read_address);
        else passes++;
        tick();
        #1;
        checks++;
        if ({bus_write_en, bus_read_en, bus_read_address} !== {1'b0, 1'b1, 3'd3})
            $display("FAIL single_rd_y: got wen=%b ren=%b addr=%0d", bus_write_en, bus_read_en, bus_read_address);
        else passes++;
        tick();
        rsp_ready = 1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 4'b1000)
            $display("FAIL single_rsp: got %b expected 1000", {rsp_valid, rsp_id, rsp_y, rsp_err});
        else passes++;
        tick();
        rsp_ready = 0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL single_idle: got rsp_valid=%b expected 0", rsp_valid);
        else passes++;
        last_id = 0;
    endtask

    task automatic test_write_stall();
        logic a, b;
        a = 1'($urandom);
        b = 1'($urandom);
        req0_a = a; req0_b = b; req0_valid = 1;
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if ({bus_write_en, bus_write_address, bus_write_data} !== {1'b1, 3'd4, a})
            $display("FAIL ws_wr_a: got en=%b addr=%0d data=%b", bus_write_en, bus_write_address, bus_write_data);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_write_rdy = 0;
            #1;
            checks++;
            if ({bus_write_en, bus_write_address} !== 4'd0)
                $display("FAIL ws_stall: got en=%b addr=%0d expected 0", bus_write_en, bus_write_address);
            else passes++;
        end
        tick();
        bus_write_rdy = 1;
        #1;
        checks++;
        if ({bus_write_en, bus_write_address, bus_write_data} !== {1'b1, 3'd5, b})
            $display("FAIL ws_wr_b: got en=%b addr=%0d data=%b", bus_write_en, bus_write_address, bus_write_data);
        else passes++;
        repeat (3) tick();
        rsp_ready = 1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, 1'b0, a ^ b, 1'b0})
            $display("FAIL ws_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, 1'b0, a ^ b, 1'b0});
        else passes++;
        tick();
        rsp_ready = 0;
        last_id = 0;
    endtask

    task automatic test_timeout();
        logic saw3 = 0;
        force_en = 1; force_status = 0; force_data = 1;
        req0_a = 1'($urandom); req0_b = 1'($urandom); req0_valid = 1;
        tick();
        req0_valid = 0;
        tick();
        for (int i = 0; i < PT; i++) begin
            tick();
            #1;
            saw3 |= bus_read_en && bus_read_address == 3'd3;
            checks++;
            if ({bus_read_en, bus_read_address, rsp_valid} !== {1'b1, 3'd2, 1'b0})
                $display("FAIL to_poll: got ren=%b addr=%0d rsp_valid=%b", bus_read_en, bus_read_address, rsp_valid);
            else passes++;
        end
        tick();
        rsp_ready = 1;
        #1;
        saw3 |= bus_read_en && bus_read_address == 3'd3;
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 4'b1001)
            $display("FAIL to_rsp: got %b expected 1001", {rsp_valid, rsp_id, rsp_y, rsp_err});
        else passes++;
        tick();
        rsp_ready = 0;
        #1;
        saw3 |= bus_read_en && bus_read_address == 3'd3;
        checks++;
        if (saw3 !== 1'b0) $display("FAIL to_no_data_read: got addr3 read=%b expected 0", saw3);
        else passes++;
        last_id = 0;
        force_en = 0;
        clear_model();
    endtask

    task automatic test_reset_mid();
        logic y, seen = 0;
        force_en = 1; force_status = 0;
        req0_a = 1; req0_b = 0; req0_valid = 1;
        tick();
        req0_valid = 0;
        repeat (3) tick();
        #1;
        checks++;
        if ({bus_read_en, bus_read_address} !== {1'b1, 3'd2})
            $display("FAIL rm_poll: got ren=%b addr=%0d expected 1/2", bus_read_en, bus_read_address);
        else passes++;
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_err, bus_write_en, bus_write_address,
             bus_write_data, bus_read_en, bus_read_address} !== 14'd0)
            $display("FAIL rm_outputs: got ren=%b raddr=%0d rsp_valid=%b expected all zero", bus_read_en, bus_read_address, rsp_valid);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            seen |= rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL rm_no_rsp: got rsp_valid seen=%b expected 0", seen);
        else passes++;
        last_id = 1;
        force_en = 0;
        clear_model();
        req0_a = 1'($urandom); req0_b = 1'($urandom); req1_a = 1'($urandom); req1_b = 1'($urandom);
        y = req0_a ^ req0_b;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rm_grant_req0: got %b expected 10", {req0_ready, req1_ready});
        else passes++;
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        for (int i = 0; i < 12 && rsp_valid !== 1'b1; i++) begin
            tick();
            #1;
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, 1'b0, y, 1'b0})
            $display("FAIL rm_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_y, rsp_err}, {1'b1, 1'b0, y, 1'b0});
        else passes++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        last_id = 0;
    endtask

    task automatic test_check();
        for (int k = 0; k < 2; k++) begin
            force_en = 1; force_status = 1; force_data = k[0];
            req0_a = 1; req0_b = 0; req0_valid = 1;
            tick();
            req0_valid = 0;
            #1;
            for (int i = 0; i < 12 && rsp_valid !== 1'b1; i++) begin
                tick();
                #1;
            end
            checks++;
            if ({rsp_valid, rsp_y, rsp_err} !== {1'b1, k[0], k == 0 ? CHK : 1'b0})
                $display("FAIL chk_rsp_%0d: got %b expected %b", k, {rsp_valid, rsp_y, rsp_err}, {1'b1, k[0], k == 0 ? CHK : 1'b0});
            else passes++;
            rsp_ready = 1;
            tick();
            rsp_ready = 0;
            last_id = 0;
        end
        force_en = 0;
        clear_model();
    endtask

    task automatic test_random();
        logic eid[$], ey[$];
        logic ok, g;
        int nrsp = 0, wlow = 0, rlow = 0;
        for (int cyc = 0; cyc < 3000 && nrsp < 20; cyc++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_a = 1'($urandom); req0_b = 1'($urandom); req1_a = 1'($urandom); req1_b = 1'($urandom);
            rsp_ready = 1'($urandom);
            bus_write_rdy = wlow >= 2 || ($urandom % 4 != 0);
            bus_read_rdy = rlow >= 2 || ($urandom % 4 != 0);
            wlow = bus_write_rdy ? 0 : wlow + 1;
            rlow = bus_read_rdy ? 0 : rlow + 1;
            #1;
            ok = !(bus_write_en && bus_read_en)
                 && (bus_write_en ? bus_write_rdy : (bus_write_address == 3'd0 && !bus_write_data))
                 && (bus_read_en ? bus_read_rdy : bus_read_address == 3'd0);
            checks++;
            if (ok !== 1'b1)
                $display("FAIL rnd_bus_rules: got wen=%b waddr=%0d ren=%b raddr=%0d wrdy=%b rrdy=%b",
                         bus_write_en, bus_write_address, bus_read_en, bus_read_address, bus_write_rdy, bus_read_rdy);
            else passes++;
            if (req0_ready || req1_ready) begin
                g = (req0_valid && req1_valid) ? !last_id : req1_valid;
                checks++;
                if ({req0_ready, req1_ready} !== {!g, g} || eid.size() != 0)
                    $display("FAIL rnd_grant: got %b expected %b outstanding=%0d", {req0_ready, req1_ready}, {!g, g}, eid.size());
                else passes++;
                eid.push_back(g);
                ey.push_back(g ? req1_a ^ req1_b : req0_a ^ req0_b);
            end
            if (rsp_valid) begin
                checks++;
                if (eid.size() == 0 || {rsp_id, rsp_y, rsp_err} !== {eid[0], ey[0], 1'b0})
                    $display("FAIL rnd_rsp: got id=%b y=%b err=%b", rsp_id, rsp_y, rsp_err);
                else passes++;
                if (rsp_ready && eid.size() != 0) begin
                    last_id = eid.pop_front();
                    void'(ey.pop_front());
                    nrsp++;
                end
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        bus_write_rdy = 1; bus_read_rdy = 1; rsp_ready = 1;
        for (int i = 0; i < 40 && eid.size() != 0; i++) begin
            #1;
            if (rsp_valid) begin
                last_id = eid.pop_front();
                void'(ey.pop_front());
            end
            tick();
        end
        checks++;
        if (nrsp < 20 || eid.size() != 0) $display("FAIL rnd_progress: got %0d responses, %0d pending", nrsp, eid.size());
        else passes++;
        rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_check();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
